// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional even parity, one stop bit.
// Defining UART_TX_PARITY_EN compiles in the even-parity bit between the last data bit and the stop bit.
module uart_tx_serializer #(
    parameter int DataWidth      = 8,
    parameter int OverSampleRate = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_i,
    input  logic                 dv_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 ready_o,
    output logic                 txd_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int TickW = $clog2(OverSampleRate);
    localparam int IdxW  = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(OverSampleRate - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DataWidth - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                 state_q;
    logic [TickW-1:0]       tick_cnt_q;
    logic [IdxW-1:0]        bit_idx_q;
    logic [DataWidth-1:0]   shift_q;
    logic [DataWidth-1:0]   shift_d;
    logic                   bit_end_d;
    logic                   txd_q;
    logic                   ready_q;
    logic                   busy_q;
    logic                   done_q;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q;
`endif

    always_comb begin
        shift_d   = shift_q >> 1;
        bit_end_d = (tick_cnt_q == TickLast);
    end

    // txd is updated together with the state so the pin only moves on accept and bit-end edges.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q == S_IDLE) begin
                if (dv_i && ready_q) begin
                    shift_q    <= data_i;
                    tick_cnt_q <= '0;
                    bit_idx_q  <= '0;
                    state_q    <= S_START;
                    txd_q      <= 1'b0;
                    busy_q     <= 1'b1;
                    ready_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_q   <= ^data_i;
`endif
                end
            end else if (tick_i) begin
                if (!bit_end_d) begin
                    tick_cnt_q <= tick_cnt_q + 1'b1;
                end else begin
                    tick_cnt_q <= '0;
                    case (state_q)
                        S_START: begin
                            state_q <= S_DATA;
                            txd_q   <= shift_q[0];
                        end
                        S_DATA: begin
                            shift_q <= shift_d;
                            if (bit_idx_q == IdxLast) begin
`ifdef UART_TX_PARITY_EN
                                state_q <= S_PARITY;
                                txd_q   <= parity_q;
`else
                                state_q <= S_STOP;
                                txd_q   <= 1'b1;
`endif
                            end else begin
                                bit_idx_q <= bit_idx_q + 1'b1;
                                txd_q     <= shift_d[0];
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        S_PARITY: begin
                            state_q <= S_STOP;
                            txd_q   <= 1'b1;
                        end
`endif
                        S_STOP: begin
                            state_q <= S_IDLE;
                            txd_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign txd_o   = txd_q;
    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: frames are queued at the handshake and checked bit by bit at the pin.
module tb_uart_tx_serializer;

    localparam int DW  = 8;
    localparam int OSR = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          tick_i;
    logic          dv_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic          txd_o;
    logic          busy_o;
    logic          done_o;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  expq[$];
    int  tcnt = 0;
    int  frame_ticks = 0;
    int  bits_done = 0;
    int  done_cnt = 0;
    int  acc_cnt = 0;
    int  done_cyc = 0;
    int  acc_cyc = 0;
    logic first_bit;
    bit  hold_err;
    int  tick_phase;

    uart_tx_serializer #(.DataWidth(DW), .OverSampleRate(OSR)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_i (tick_i),
        .dv_i   (dv_i),
        .data_i (data_i),
        .ready_o(ready_o),
        .txd_o  (txd_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push_frame(input logic [DW-1:0] w);
        expq.push_back(1'b0);
        for (int i = 0; i < DW; i++) expq.push_back(w[i]);
`ifdef UART_TX_PARITY_EN
        expq.push_back(^w);
`endif
        expq.push_back(1'b1);
    endfunction

    // Oversample tick: one-cycle pulse every third clock.
    initial begin
        tick_i = 1'b0;
        tick_phase = 0;
        forever begin
            @(posedge clk_i);
            #1;
            tick_i = (tick_phase == 2);
            tick_phase = (tick_phase == 2) ? 0 : tick_phase + 1;
        end
    end

    // Pin monitor and handshake observer, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            expq.delete();
            tcnt = 0;
            frame_ticks = 0;
            bits_done = 0;
        end else begin
            if (busy_o && tick_i) begin
                if (tcnt == 0) begin
                    first_bit = txd_o;
                    hold_err = 1'b0;
                end else if (txd_o !== first_bit) begin
                    hold_err = 1'b1;
                end
                tcnt++;
                frame_ticks++;
                if (tcnt == OSR) begin
                    if (expq.size() == 0) check("extra_bit", 32'd1, 32'd0);
                    else check("bit", 32'(first_bit), 32'(expq.pop_front()));
                    check("bit_hold", 32'(hold_err), 32'd0);
                    tcnt = 0;
                    bits_done++;
                end
            end
            if (done_o) begin
                check("done_ticks", 32'(frame_ticks), 32'(NBITS * OSR));
                check("frame_left", 32'(expq.size()), 32'd0);
                frame_ticks = 0;
                bits_done = 0;
                done_cnt++;
                done_cyc = cyc;
            end
            if (dv_i && ready_o) begin
                push_frame(data_i);
                acc_cnt++;
                acc_cyc = cyc;
            end
        end
    end

    task automatic wait_acc(input int start, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_i);
            #1;
            if (acc_cnt != start) return;
        end
        check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int s;
        s = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_i);
            #1;
            if (done_cnt != s) return;
        end
        check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic send(input logic [DW-1:0] w);
        int s;
        s = acc_cnt;
        dv_i = 1'b1;
        data_i = w;
        wait_acc(s, 2000, "acc");
        dv_i = 1'b0;
    endtask

    initial begin
        int changes;
        int s;
        int d0;
        rst_i = 1'b1;
        dv_i = 1'b0;
        data_i = '0;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_txd", 32'(txd_o), 32'd1);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        rst_i = 1'b0;

        changes = 0;
        repeat (100) begin
            @(negedge clk_i);
            if ({txd_o, ready_o, busy_o, done_o} !== 4'b1100) changes++;
        end
        check("idle_stable", 32'(changes), 32'd0);

        // Basic frame, then parity-relevant words.
        @(posedge clk_i);
        #1;
        d0 = done_cnt;
        send(8'hA5);
        wait_done(1000, "a5_done");
        repeat (20) @(posedge clk_i);
        #1;
        check("a5_done_count", 32'(done_cnt - d0), 32'd1);
        send(8'h07);
        wait_done(1000, "07_done");

        // Handshake: dv held with a new word during an active frame.
        send(8'hA5);
        repeat (20) @(posedge clk_i);
        #1;
        s = acc_cnt;
        dv_i = 1'b1;
        data_i = 8'h3C;
        repeat (5) begin
            @(negedge clk_i);
            check("hs_ready_low", 32'(ready_o), 32'd0);
        end
        wait_acc(s, 1000, "hs_acc");
        check("hs_gap", 32'(acc_cyc - done_cyc), 32'd0);
        dv_i = 1'b0;
        wait_done(1000, "3c_done");

        // Back-to-back stream.
        repeat (5) @(posedge clk_i);
        #1;
        s = acc_cnt;
        dv_i = 1'b1;
        data_i = 8'h55;
        wait_acc(s, 1000, "b2b_acc0");
        s = acc_cnt;
        data_i = 8'hAA;
        wait_acc(s, 1000, "b2b_acc1");
        check("b2b_gap", 32'(acc_cyc - done_cyc), 32'd0);
        dv_i = 1'b0;
        wait_done(1000, "aa_done");

        // Reset during the fourth data bit (0xA5 bit 3 drives txd low).
        repeat (5) @(posedge clk_i);
        #1;
        send(8'hA5);
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 1000 && !hit; i++) begin
                @(posedge clk_i);
                #1;
                if (bits_done == 4 && tcnt == 1) hit = 1'b1;
            end
            if (!hit) check("midrst_timeout", 32'd1, 32'd0);
        end
        check("midrst_pre_txd", 32'(txd_o), 32'd0);
        #2;
        d0 = done_cnt;
        rst_i = 1'b1;
        #1;
        check("midrst_txd", 32'(txd_o), 32'd1);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_ready", 32'(ready_o), 32'd1);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (200) @(posedge clk_i);
        #1;
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        send(8'h0F);
        wait_done(1000, "0f_done");
        check("0f_done_count", 32'(done_cnt - d0), 32'd1);

        repeat (10) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
